// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // IDLE waits for operands, CALC walks one bit per clock, DONE holds the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub.
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both 1; the sender holds its data stable from raising valid until that edge.
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   Diff;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Diff
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Diff
    );
endinterface

// File: rtl/serial_sub_full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    // Difference bit and borrow-out of a single column.
    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: Diff = A - B - Bin on WIDTH+1 bits, one bit per clock,
// LSB first. One full_sub cell is reused across WIDTH CALC cycles.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    serial_sub_if.slave    bus,
    output state_t         o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_next;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_diff;
    logic             w_d;
    logic             w_bout;
    logic             w_last;

    full_sub u_full_sub (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // The last CALC edge is the one that processes bit WIDTH-1.
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // New difference bits enter from the MSB side so bit 0 ends up at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign w_res_next = w_d;
        end else begin : g_res_many
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    assign bus.Diff    = r_diff;
    assign o_dbg_state = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; both handshakes are plain state decodes.
    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand shift registers, running borrow, bit counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_borrow <= bus.Bin;
                        r_res    <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_bout;
                    r_res    <= w_res_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff <= {w_bout, w_res_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed cases, backpressure, reset
// abort and randomized operations against an arithmetic reference.
module tb_serial_sub;
    import serial_sub_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   reset = 1'b1;
    state_t dbg_state;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W:0]       exp_q[$];
    logic [2*W:0]     vec_q[$];
    int               acc_q[$];
    int               checks   = 0;
    int               failures = 0;
    bit               stall_en = 1'b0;
    bit               prev_valid = 1'b0;

    function automatic logic [W:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic bin);
        return (W+1)'(a) - (W+1)'(b) - (W+1)'(bin);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [W:0]   m_exp;
    logic [2*W:0] m_vec;
    int           m_acc;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && !prev_valid) begin
                if (acc_q.size() == 0) begin
                    check("latency_unexpected_valid", 1, 0);
                end else begin
                    m_acc = acc_q.pop_front();
                    check("latency", cyc - m_acc, W);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("diff_unexpected", 1, 0);
                end else begin
                    m_exp = exp_q.pop_front();
                    m_vec = vec_q.pop_front();
                    checks++;
                    if (bus.Diff !== m_exp) begin
                        failures++;
                        $display("FAIL diff A=%h B=%h Bin=%b got=%h exp=%h",
                                 m_vec[2*W:W+1], m_vec[W:1], m_vec[0], bus.Diff, m_exp);
                    end
                end
            end
        end
        prev_valid = bus.out_valid;
    end

    // Random output stalls.
    always @(posedge clk) begin
        #1;
        if (stall_en) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int n = 0;
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(ref_diff(a, b, bin));
                vec_q.push_back({a, b, bin});
                acc_q.push_back(cyc + 1);
                done = 1'b1;
            end else if (++n > 300) begin
                check("issue_timeout", 0, 1);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input bit chk_idle);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain", exp_q.size(), 0);
        if (chk_idle) begin
            @(negedge clk);
            check("in_ready_after_handoff", bus.in_ready, 1);
            check("out_valid_after_handoff", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] ta[4];
    logic [W-1:0] tb_[4];
    logic         tbin[4];

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_diff", bus.Diff, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_in_ready", bus.in_ready, 1);
            check("idle_out_valid", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Basic and boundary operations.
        bus.out_ready = 1'b1;
        issue(4'h9, 4'h3, 1'b0);
        drain(1'b1);
        ta[0] = 4'h3; tb_[0] = 4'h9; tbin[0] = 1'b1;
        ta[1] = 4'h0; tb_[1] = 4'h0; tbin[1] = 1'b1;
        ta[2] = 4'hF; tb_[2] = 4'hF; tbin[2] = 1'b0;
        ta[3] = 4'hF; tb_[3] = 4'h0; tbin[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb_[i], tbin[i]);
            drain(1'b1);
        end

        // Backpressure: result must hold and new operands must be dropped.
        bus.out_ready = 1'b0;
        issue(4'h5, 4'h2, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 50);
        check("bp_out_valid_rise", bus.out_valid, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.A        = 4'h1;
        bus.B        = 4'h1;
        repeat (3) begin
            @(negedge clk);
            check("bp_diff_hold", bus.Diff, 5'h03);
            check("bp_out_valid_hold", bus.out_valid, 1);
            check("bp_in_ready_low", bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain(1'b1);

        // Reset in the middle of CALC.
        issue(4'h7, 4'h1, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        vec_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_diff", bus.Diff, 0);
        check("abort_state", dbg_state, IDLE);
        @(posedge clk);
        #1;
        issue(4'h8, 4'h1, 1'b0);
        drain(1'b1);

        // Random operations with output stalls.
        stall_en = 1'b1;
        repeat (150) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            issue(W'($urandom), W'($urandom), 1'($urandom));
        end
        stall_en      = 1'b0;
        bus.out_ready = 1'b1;
        drain(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
